// File: rtl/cheetah_lsu_pkg.sv
// cheetah_lsu_pkg: shared LSU IO bridge state encoding and sentinel values
package cheetah_lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [31:0] IO_IDLE_SENTINEL = 32'hDEADBEEF;
  localparam logic [31:0] IO_ERR_SENTINEL = 32'hBABECAFE;
endpackage

// File: rtl/lsu_io_timer.sv
// lsu_io_timer: saturating wait counter for the IO bridge timeout
module lsu_io_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  logic sat;
  assign sat = 32'(cnt) >= LIMIT;
  // high when the increment happening this cycle reaches the limit
  assign expired = 32'(cnt) + 32'd1 >= LIMIT;
  always_ff @(posedge clk)
    if (!rst_n || clear) cnt <= '0;
    else if (enable && !sat) cnt <= cnt + 1'b1;
endmodule

// File: rtl/lsu_io_bridge.sv
// lsu_io_bridge: stalls the core while a load/store to the IO window runs on the bus
module lsu_io_bridge
  import cheetah_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [3:0]  mask,
  output logic        stall,
  output logic [31:0] toLSU,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  state_t state, next;
  logic req, expired, err_q;
  logic [31:0] rdata_q;
  assign req = (mem_rd | mem_wr) & (|addr[15:8]);
  lsu_io_timer #(.LIMIT(TIMEOUT_CYCLES)) timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state == IDLE && req),
    .enable(state == REQ && !bus_ready),
    .expired(expired)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      rdata_q <= IO_IDLE_SENTINEL;
      err_q <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_be <= '0;
      bus_we <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && req) begin
        bus_addr <= addr;
        bus_wdata <= wdata;
        bus_be <= mask;
        bus_we <= mem_wr & ~mem_rd;
        err_q <= 1'b0;
      end
      // ready beats timeout in the same cycle
      if (state == REQ && bus_ready && !bus_we) rdata_q <= bus_rdata;
      if (state == REQ && !bus_ready && expired) err_q <= 1'b1;
    end
  always_comb begin
    next = state == IDLE ? (req ? REQ : IDLE) :
           state == REQ  ? (bus_ready || expired ? DONE : REQ) : IDLE;
    stall = (state == IDLE && req) || state == REQ;
    bus_valid = state == REQ;
    toLSU = state != DONE ? IO_IDLE_SENTINEL :
            err_q ? IO_ERR_SENTINEL :
            bus_we ? IO_IDLE_SENTINEL : rdata_q;
  end
endmodule

// File: doc/lsu_io_bridge.md
LSU_IO_BRIDGE -- requirements
Module: lsu_io_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles in REQ before the access is abandoned.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 Port addr, input, 32: core data address for the current load or store.
REQ-005 Port wdata, input, 32: core store data.
REQ-006 Port mem_rd, input, 1: core load request.
REQ-007 Port mem_wr, input, 1: core store request.
REQ-008 Port mask, input, 4: store byte enables.
REQ-009 Port stall, output, 1: holds the core pipeline.
REQ-010 Port toLSU, output, 32: IO read data, or a sentinel, to the downstream memory mux.
REQ-011 Port bus_valid, output, 1: IO bus request valid.
REQ-012 Port bus_addr, output, 32: IO bus address.
REQ-013 Port bus_wdata, output, 32: IO bus write data.
REQ-014 Port bus_we, output, 1: IO bus write enable.
REQ-015 Port bus_be, output, 4: IO bus byte enables.
REQ-016 Port bus_ready, input, 1: IO bus accept/complete.
REQ-017 Port bus_rdata, input, 32: IO bus read data, valid when bus_ready is high.

Function
REQ-018 io_hit SHALL equal OR(addr[15:8]); a request is (mem_rd|mem_wr)&io_hit; mem_rd takes priority if both are high.
REQ-019 FSM states SHALL be IDLE, REQ and DONE.
REQ-020 IDLE: on a request, latch addr, wdata, mask and we=mem_wr (we=0 if mem_rd is high), clear the counter, go to REQ; otherwise stay in IDLE.
REQ-021 stall SHALL equal (IDLE & request) | REQ, combinationally; stall SHALL be 0 in DONE.
REQ-022 REQ: bus_valid=1 and bus_addr/bus_wdata/bus_we/bus_be driven from the latched values, held stable until bus_ready or timeout.
REQ-023 REQ with bus_ready=1: capture bus_rdata if it is a read, go to DONE; bus_valid SHALL be 0 from the next cycle.
REQ-024 REQ with bus_ready=0: increment the counter; when the counter reaches TIMEOUT_CYCLES, go to DONE with error flagged.
REQ-025 bus_ready and timeout in the same cycle: bus_ready SHALL win (normal completion).
REQ-026 DONE lasts exactly one cycle, then IDLE; requests present during DONE SHALL be ignored, because they are the completing instruction.
REQ-027 toLSU SHALL be 32'hDEADBEEF in IDLE and REQ, in DONE after a write, and after reset.
REQ-028 toLSU SHALL be the captured bus_rdata in DONE after a successful read.
REQ-029 toLSU SHALL be 32'hBABECAFE in DONE after a timeout, for both reads and writes.
REQ-030 Minimum read latency: request at cycle 0, bus_ready at cycle 1, data on toLSU with stall=0 at cycle 2.
REQ-031 The counter SHALL saturate; it SHALL NOT wrap.
REQ-032 Bus read data equal to either sentinel is indistinguishable from no-data downstream; IO devices SHALL NOT return those values.
REQ-033 Non-IO requests (io_hit=0) SHALL cause no bus activity and no stall.

Reset
REQ-034 rst_n=0 at an edge: state to IDLE, counter to 0, captured data to 32'hDEADBEEF, error flag to 0.
REQ-035 rst_n=0 at an edge: bus_valid low from that edge, including when asserted mid-REQ; the in-flight access is dropped with no response.
REQ-036 Reset SHALL NOT be sampled asynchronously.

Structure
REQ-037 Package cheetah_lsu_pkg SHALL hold the state enum and the constants IO_IDLE_SENTINEL=32'hDEADBEEF and IO_ERR_SENTINEL=32'hBABECAFE; the memory mux SHALL use the same constants.
REQ-038 The saturating timeout counter SHALL be a sub-module lsu_io_timer (ports: clear, enable, expired).

Verification
REQ-039 Read: addr=0x0000_0100, mem_rd=1, bus_ready at cycle 1 with rdata=0x1234_5678 -> stall 1,1,0; toLSU=0x1234_5678 at cycle 2, 0xDEADBEEF at cycle 3.
REQ-040 Write: addr=0x0000_0204, wdata=0xA5A5_A5A5, mask=0x3, bus_ready after 3 cycles -> bus fields stable throughout, bus_we=1, bus_be=0x3; toLSU stays 0xDEADBEEF.
REQ-041 Timeout: TIMEOUT_CYCLES=4, bus_ready held 0 -> bus_valid drops after 4 REQ cycles; toLSU=0xBABECAFE for one cycle; stall released.
REQ-042 Non-IO: addr=0x0000_00FC, mem_rd=1 -> stall=0, bus_valid=0, toLSU=0xDEADBEEF.
REQ-043 Reset mid-REQ: rst_n=0 for one cycle at REQ cycle 2 -> bus_valid=0 and state IDLE at the next edge; no DONE cycle occurs.
REQ-044 Simultaneous: bus_ready=1 in the same cycle the counter expires -> normal completion; toLSU shows bus_rdata, not 0xBABECAFE.
